// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: the write side of the BTB.
// Keeps every fetch-stage prediction in an in-order queue. When an instruction
// leaves EX it is checked against the queue head. On a mispredict this block
// raises a registered flush/redirect. It also drives the BTB update port and
// keeps saturating performance counters.
module branch_resolve_unit #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid,
    input  logic             if_stall,
    input  logic [31:0]      if_pc,
    input  logic             if_pred_taken,
    input  logic [31:0]      if_pred_target,
    input  logic             ex_valid,
    input  logic [31:0]      ex_pc,
    input  logic             ex_is_branch,
    input  logic             ex_taken,
    input  logic [31:0]      ex_target,
    input  logic             ext_flush,
    output logic             fetch_hold,
    output logic             flush,
    output logic [31:0]      redirect_pc,
    output logic             update,
    output logic [31:0]      update_pc,
    output logic [31:0]      update_target,
    output logic             mispredicted,
    output logic             sync_error,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Prediction storage, one slot per in-flight fetch
    logic [31:0]   slot_pc_reg     [DEPTH];
    logic          slot_taken_reg  [DEPTH];
    logic [31:0]   slot_target_reg [DEPTH];

    logic [AW-1:0] head_reg;
    logic [AW-1:0] tail_reg;
    logic [AW:0]   count_reg;

    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic          kill;

    logic [31:0]   head_pc;
    logic          head_taken;
    logic [31:0]   head_target;

    logic          pc_mismatch;
    logic          dir_mis;
    logic          mis;
    logic          mis_pop;
    logic          need_update;
    logic [31:0]   seq_pc;
    logic [31:0]   correct_pc;
    logic [31:0]   install_target;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == (AW+1)'(DEPTH));

    // A pop only needs ex_valid. This keeps fetch_hold free of ex_pc/ex_taken
    // timing.
    assign pop        = ex_valid & ~empty;
    assign fetch_hold = full & ~pop;

    assign head_pc     = slot_pc_reg[head_reg];
    assign head_taken  = slot_taken_reg[head_reg];
    assign head_target = slot_target_reg[head_reg];

    // A PC mismatch means the queue lost sync with the pipeline. It is
    // treated as a mispredict, so the redirect re-aligns fetch.
    assign pc_mismatch = (head_pc != ex_pc);
    assign dir_mis     = ex_is_branch
                       ? ((head_taken != ex_taken) | (ex_taken & (head_target != ex_target)))
                       : head_taken;
    assign mis         = pc_mismatch | dir_mis;
    assign mis_pop     = pop & mis;

    // Either kill source empties the queue and drops this cycle's push, since
    // that fetch is on the wrong path.
    assign kill = mis_pop | ext_flush;
    assign push = if_valid & ~if_stall & ~fetch_hold & ~kill;

    assign seq_pc         = ex_pc + 32'd4;
    assign correct_pc     = (ex_is_branch & ex_taken) ? ex_target : seq_pc;
    // A non-branch that was predicted taken installs its fall-through address,
    // which evicts the aliasing BTB entry.
    assign install_target = ex_is_branch ? ex_target : seq_pc;
    assign need_update    = pop & ((ex_is_branch & ex_taken) | mis);

    // Per-slot capture of the fetch-stage prediction (data only, no reset needed)
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (push && (tail_reg == AW'(gi))) begin
                    slot_pc_reg[gi]     <= if_pc;
                    slot_taken_reg[gi]  <= if_pred_taken;
                    slot_target_reg[gi] <= if_pred_target;
                end
            end
        end
    endgenerate

    // Queue pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else if (kill) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push) begin
                tail_reg <= tail_reg + 1'b1;
            end
            if (pop) begin
                head_reg <= head_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Registered flush/redirect pulse; redirect_pc holds between flushes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush       <= 1'b0;
            redirect_pc <= 32'h0;
        end else begin
            flush <= mis_pop;
            if (mis_pop) begin
                redirect_pc <= correct_pc;
            end
        end
    end

    // BTB update strobe; the address/target/qualifier hold their last value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            update        <= 1'b0;
            update_pc     <= 32'h0;
            update_target <= 32'h0;
            mispredicted  <= 1'b0;
        end else begin
            update <= need_update;
            if (need_update) begin
                update_pc     <= ex_pc;
                update_target <= install_target;
                mispredicted  <= mis;
            end
        end
    end

    // Sticky sync error: a head PC mismatch, or a retire with nothing queued
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_error <= 1'b0;
        end else if ((pop && pc_mismatch) || (ex_valid && empty)) begin
            sync_error <= 1'b1;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (pop && ex_is_branch && (branch_cnt != '1)) begin
                branch_cnt <= branch_cnt + 1'b1;
            end
            if (mis_pop && (mispred_cnt != '1)) begin
                mispred_cnt <= mispred_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit.
// The directed scenarios run first, then a randomized run. A queue-based
// reference model predicts every registered output.
module tb_branch_resolve_unit;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int SAT   = 15;

    logic             clk = 1'b0;
    logic             rst;
    logic             if_valid, if_stall, if_pred_taken;
    logic [31:0]      if_pc, if_pred_target;
    logic             ex_valid, ex_is_branch, ex_taken, ext_flush;
    logic [31:0]      ex_pc, ex_target;
    logic             fetch_hold, flush, update, mispredicted, sync_error;
    logic [31:0]      redirect_pc, update_pc, update_target;
    logic [CNT_W-1:0] branch_cnt, mispred_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] pc;
        logic        pt;
        logic [31:0] tgt;
    } ent_t;

    ent_t        q[$];
    bit          e_flush, e_update, e_mis, e_sync;
    logic [31:0] e_redirect, e_upc, e_utgt;
    int          e_bcnt, e_mcnt;

    branch_resolve_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_stall(if_stall), .if_pc(if_pc),
        .if_pred_taken(if_pred_taken), .if_pred_target(if_pred_target),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_is_branch(ex_is_branch),
        .ex_taken(ex_taken), .ex_target(ex_target), .ext_flush(ext_flush),
        .fetch_hold(fetch_hold), .flush(flush), .redirect_pc(redirect_pc),
        .update(update), .update_pc(update_pc), .update_target(update_target),
        .mispredicted(mispredicted), .sync_error(sync_error),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        e_flush = 0; e_update = 0; e_mis = 0; e_sync = 0;
        e_redirect = 0; e_upc = 0; e_utgt = 0; e_bcnt = 0; e_mcnt = 0;
    endtask

    task automatic idle();
        if_valid = 0; if_stall = 0; if_pc = 0; if_pred_taken = 0; if_pred_target = 0;
        ex_valid = 0; ex_pc = 0; ex_is_branch = 0; ex_taken = 0; ex_target = 0;
        ext_flush = 0;
    endtask

    task automatic set_push(input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
        if_valid = 1; if_pc = pc; if_pred_taken = pt; if_pred_target = tgt;
    endtask

    task automatic set_ex(input logic [31:0] pc, input logic br, input logic tk, input logic [31:0] tgt);
        ex_valid = 1; ex_pc = pc; ex_is_branch = br; ex_taken = tk; ex_target = tgt;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_flush"}, {31'b0, flush}, {31'b0, e_flush});
        if (e_flush) check({tag, "_redirect"}, redirect_pc, e_redirect);
        check({tag, "_update"}, {31'b0, update}, {31'b0, e_update});
        check({tag, "_upc"}, update_pc, e_upc);
        check({tag, "_utgt"}, update_target, e_utgt);
        check({tag, "_mispredicted"}, {31'b0, mispredicted}, {31'b0, e_mis});
        check({tag, "_sync"}, {31'b0, sync_error}, {31'b0, e_sync});
        check({tag, "_bcnt"}, 32'(branch_cnt), 32'(e_bcnt));
        check({tag, "_mcnt"}, 32'(mispred_cnt), 32'(e_mcnt));
    endtask

    // One clock: check fetch_hold, advance the model from the spec rules, then check outputs
    task automatic cycle(input string tag);
        ent_t        h;
        bit          hold, do_pop, m, kill, n_flush, n_update;
        logic [31:0] corr;
        #1;
        hold = (q.size() == DEPTH) && !ex_valid;
        check({tag, "_fetch_hold"}, {31'b0, fetch_hold}, {31'b0, hold});
        do_pop = ex_valid && (q.size() != 0);
        m = 0; n_flush = 0; n_update = 0;
        if (ex_valid && q.size() == 0) e_sync = 1;
        if (do_pop) begin
            h = q.pop_front();
            if (h.pc != ex_pc) begin
                e_sync = 1;
                m = 1;
            end else if (ex_is_branch) begin
                m = (h.pt != ex_taken) || (ex_taken && (h.tgt != ex_target));
            end else begin
                m = h.pt;
            end
            corr = (ex_is_branch && ex_taken) ? ex_target : ex_pc + 32'd4;
            if (m) begin
                n_flush = 1;
                e_redirect = corr;
            end
            if (m || (ex_is_branch && ex_taken)) begin
                n_update = 1;
                e_upc = ex_pc;
                e_utgt = ex_is_branch ? ex_target : ex_pc + 32'd4;
                e_mis = m;
            end
            if (ex_is_branch && e_bcnt < SAT) e_bcnt++;
            if (m && e_mcnt < SAT) e_mcnt++;
        end
        kill = m || ext_flush;
        if (kill) q.delete();
        else if (if_valid && !if_stall && !hold) q.push_back('{if_pc, if_pred_taken, if_pred_target});
        @(posedge clk);
        #1;
        e_flush = n_flush;
        e_update = n_update;
        check_outputs(tag);
    endtask

    initial begin
        int unsigned fpc;
        rst = 1;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        check("reset_fetch_hold", {31'b0, fetch_hold}, 32'h0);
        rst = 0;

        // Branch predicted not-taken resolves taken
        set_push(32'h100, 0, 32'h0); cycle("t1_push");
        idle(); set_ex(32'h100, 1, 1, 32'h200); cycle("t1_pop");
        check("t1_redirect_lit", redirect_pc, 32'h200);
        check("t1_utgt_lit", update_target, 32'h200);

        // Correctly predicted taken branch
        idle(); set_push(32'h40, 1, 32'h80); cycle("t2_push");
        idle(); set_ex(32'h40, 1, 1, 32'h80); cycle("t2_pop");
        check("t2_mispredicted_lit", {31'b0, mispredicted}, 32'h0);

        // Predicted-taken non-branch
        idle(); set_push(32'h10, 1, 32'h50); cycle("t3_push");
        idle(); set_ex(32'h10, 0, 0, 32'h0); cycle("t3_pop");
        check("t3_redirect_lit", redirect_pc, 32'h14);
        check("t3_utgt_lit", update_target, 32'h14);

        // Fill to DEPTH, an ignored push at full, then push+pop at full
        for (int i = 0; i < DEPTH; i++) begin
            idle(); set_push(32'h200 + 32'(4 * i), 0, 32'h0); cycle("t4_fill");
        end
        idle(); set_push(32'h2f0, 1, 32'h999); cycle("t4_full_push");
        check("t4_hold_lit", {31'b0, fetch_hold}, 32'h1);
        idle(); set_push(32'h210, 0, 32'h0); set_ex(32'h200, 0, 0, 32'h0); cycle("t4_full_pushpop");
        for (int i = 1; i <= DEPTH; i++) begin
            idle(); set_ex(32'h200 + 32'(4 * i), 0, 0, 32'h0); cycle("t4_drain");
        end
        check("t4_sync_lit", {31'b0, sync_error}, 32'h0);

        // Mispredict pop with a simultaneous push: the push is discarded
        idle(); set_push(32'h300, 0, 32'h0); cycle("t5_push");
        idle(); set_ex(32'h300, 1, 1, 32'h400); set_push(32'h304, 0, 32'h0); cycle("t5_mis_push");
        idle(); set_ex(32'h304, 0, 0, 32'h0); cycle("t5_orphan");
        check("t5_sync_lit", {31'b0, sync_error}, 32'h1);

        // Reset between a mispredicting pop and its registered flush
        idle(); set_push(32'h500, 0, 32'h0); cycle("t6_push");
        idle(); set_ex(32'h500, 1, 1, 32'h600);
        #3;
        rst = 1;
        #1;
        check("t6_flush_async", {31'b0, flush}, 32'h0);
        check("t6_update_async", {31'b0, update}, 32'h0);
        check("t6_bcnt_async", 32'(branch_cnt), 32'h0);
        check("t6_mcnt_async", 32'(mispred_cnt), 32'h0);
        check("t6_sync_async", {31'b0, sync_error}, 32'h0);
        @(posedge clk);
        #1;
        check("t6_flush_after", {31'b0, flush}, 32'h0);
        check("t6_update_after", {31'b0, update}, 32'h0);
        model_reset();
        idle();
        rst = 0;

        // Randomized traffic against the model
        fpc = 32'h1000;
        for (int n = 0; n < 600; n++) begin
            idle();
            if ($urandom_range(0, 9) < 7) begin
                set_push(fpc, ($urandom_range(0, 9) < 3), 32'($urandom_range(0, 15)) << 4);
                if_stall = ($urandom_range(0, 9) == 0);
            end
            fpc += 4;
            if (q.size() != 0 && $urandom_range(0, 1) == 1) begin
                set_ex(($urandom_range(0, 19) == 0) ? 32'($urandom) : q[0].pc,
                       ($urandom_range(0, 9) < 6), $urandom_range(0, 1) == 1,
                       ($urandom_range(0, 9) < 7) ? q[0].tgt : 32'($urandom_range(0, 15)) << 4);
            end else if (q.size() == 0 && $urandom_range(0, 49) == 0) begin
                set_ex(32'($urandom), 1, 1, 32'h0);
            end
            ext_flush = ($urandom_range(0, 32) == 0);
            cycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
